// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two data-memory requesters, dm_arbiter and data_memory.
// The slave modport is the arbiter's view; master is the environment's view
// (requesters plus the memory's read data).
interface dm_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    // Port 0 (CPU data port)
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;
    // Port 1 (auxiliary master)
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;
    // Memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    // Status
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Each access is one grant cycle, WAIT_STATES extra SERVE cycles, then a
// one-cycle DONE with the ack pulse and registered read data.
// Optional macro DM_ARB_ROUND_ROBIN_EN: on a tie the port that was not served
// last wins; otherwise port 0 always wins a tie.
module dm_arbiter #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic         clk,
    input logic         rst,
    dm_arbiter_if.slave bus
);

    localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StServe, StDone} state_e;

    state_e            state_q, state_d;
    logic              winner_q, winner_d;
    logic              lat_we_q, lat_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic elig0, elig1, pick1;

    // A request seen during its own ack cycle is not eligible.
    assign elig0 = bus.req0 & ~ack0_q;
    assign elig1 = bus.req1 & ~ack1_q;

    // Winner selection among eligible requesters (1 = port 1).
`ifdef DM_ARB_ROUND_ROBIN_EN
    assign pick1 = elig1 & (~elig0 | ~last_q);
`else
    assign pick1 = elig1 & ~elig0;
`endif

    // Next-state, memory-side latching and ack generation.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        lat_we_d = lat_we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mem_we_d = 1'b0;
        cnt_d    = cnt_q;
        last_d   = last_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            StIdle: begin
                if (elig0 | elig1) begin
                    winner_d = pick1;
                    lat_we_d = pick1 ? bus.we1    : bus.we0;
                    addr_d   = pick1 ? bus.addr1  : bus.addr0;
                    wdata_d  = pick1 ? bus.wdata1 : bus.wdata0;
                    mem_we_d = lat_we_d;
                    cnt_d    = WaitInit;
                    state_d  = StServe;
                end
            end
            StServe: begin
                if (cnt_q != 4'd0) begin
                    // Write stays asserted; address/data are stable, so repeats are harmless.
                    mem_we_d = lat_we_q;
                    cnt_d    = cnt_q - 4'd1;
                end else begin
                    if (!lat_we_q) begin
                        if (winner_q) rdata1_d = bus.mem_rdata;
                        else          rdata0_d = bus.mem_rdata;
                    end
                    ack0_d  = ~winner_q;
                    ack1_d  = winner_q;
                    last_d  = winner_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            winner_q <= 1'b0;
            lat_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mem_we_q <= 1'b0;
            cnt_q    <= 4'd0;
            last_q   <= 1'b1;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            lat_we_q <= lat_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mem_we_q <= mem_we_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory (8-bit address, 8-bit data, combinational read, MW write enable) between two requesters.
- Port 0 is the CPU data port. Port 1 is an auxiliary master, such as a keyboard/input buffer engine or DMA.
- Sequences each access as one grant, a programmable number of wait states, and a one-cycle acknowledge with registered read data.
- Sits between the requesters and data_memory inside the MCU top level.

Parameters:
- ADDR_W, 8, address width of requesters and memory.
- DATA_W, 8, data width.
- WAIT_STATES, 0, extra cycles the memory-side signals are held before read data is captured (0..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 access request; held high until ack0.
- we0  input  1  port 0 write (1) / read (0); valid while req0 is high.
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  one-cycle completion pulse to port 0.
- rdata0  output  DATA_W  port 0 registered read data.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_addr  output  ADDR_W  to data_memory address_in_bus.
- mem_wdata  output  DATA_W  to data_memory data_in_bus.
- mem_we  output  1  to data_memory MW.
- mem_rdata  input  DATA_W  from data_memory data_out_bus.
- busy  output  1  high in SERVE and DONE.

Behaviour:
- Reset (rst=0, asynchronous), applied immediately:
  - state = IDLE.
  - ack0, ack1, mem_we, busy = 0.
  - mem_addr, mem_wdata, rdata0, rdata1 = 0.
  - wait counter = 0; last_served = 1.
- An access in progress when reset asserts is aborted: no ack is issued and the write is dropped.
- FSM states: IDLE, SERVE, DONE.
- IDLE:
  - Eligible request = reqN high and ackN low in that cycle. A req still high during its own ack cycle is ignored.
  - If none eligible: stay in IDLE.
  - Otherwise select a winner per the arbitration rule and latch its we/addr/wdata into the memory-side registers. Load the wait counter with WAIT_STATES and go to SERVE.
- SERVE:
  - mem_addr and mem_wdata come from the latched values.
  - mem_we = latched we for every SERVE cycle. Address and data are stable throughout, so the write is idempotent.
  - If the counter is not 0: decrement it and stay in SERVE.
  - If the counter is 0: capture mem_rdata into the winner's rdata (reads only; rdata is unchanged on writes), set last_served = winner, and go to DONE.
- DONE:
  - Winner's ack = 1 for exactly one cycle; mem_we = 0.
  - Next state is IDLE. No arbitration occurs in DONE.
- Latency: a req first sampled at edge E gives ack high in the cycle after edge E+1+WAIT_STATES.
- Throughput: one access per 3+WAIT_STATES cycles.
- Arbitration (default): fixed priority; when both are eligible, port 0 wins.
- A request is never preempted once granted. The losing request stays pending and is served on the next IDLE.
- rdataN holds its value until that port's next read completes.
- Address and data pass through unchanged; there is no arithmetic or wrap logic.
- Changing addrN/weN/wdataN while reqN is high and the port is not yet granted is allowed; the value is sampled at grant.
- Changing them after grant has no effect on the access in flight.
- mem_addr, mem_wdata and mem_we are registered; there is no combinational path from the requester ports.

Optional Feature:
- Macro: DM_ARB_ROUND_ROBIN_EN.
- Defined: when both ports are eligible in IDLE, the port not equal to last_served wins. last_served resets to 1, so port 0 wins the first tie. A single eligible requester always wins regardless of last_served.
- Undefined: fixed priority to port 0. last_served is still maintained but does not influence selection.

Test Plan:
- Reset, then preload mem[0x10]=0xA5, WAIT_STATES=0; pulse req0 read addr 0x10 -> ack0 high exactly 2 cycles after the sampling edge, rdata0=0xA5, ack1 stays 0.
- req1 write addr 0x20 data 0x3C -> mem_we high for exactly 1 cycle with mem_addr=0x20 and mem_wdata=0x3C. A following port-0 read of 0x20 returns 0x3C.
- req0 and req1 asserted in the same cycle and held, no macro -> ack0 first, ack1 next completion. With DM_ARB_ROUND_ROBIN_EN and both held continuously for 4 accesses -> ack order 0,1,0,1.
- WAIT_STATES=2, port 0 write addr 0x05 -> mem_we high for 3 consecutive cycles, ack0 4 cycles after the sampling edge, busy high for 4 cycles.
- Assert rst low during SERVE of a port-1 write to 0x40 (old value 0x11) -> mem_we drops in the same cycle, no ack1, mem[0x40] remains 0x11, all outputs 0.
- req0 kept high through its ack cycle and deasserted the cycle after -> exactly one ack0, then a second access starts only if req0 is still high in IDLE.
